// File: rtl/mem_pkg.sv
// mem_pkg: encodings and helpers shared by the data-memory access unit.
//   DATA_W          memory word width (one 64-bit word per address index)
//   SIZE_B/H/W/D    request size encodings (byte, half, word, dword)
//   state_t         access-unit FSM states
//   is_aligned()    natural-alignment check of a byte offset for a given size
package mem_pkg;

  localparam int DATA_W = 64;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    MERGE_WR,
    WR,
    RESP,
    ERR
  } state_t;

  function automatic logic is_aligned(input logic [2:0] offset, input logic [1:0] size);
    logic ok;
    case (size)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = (offset[0] == 1'b0);
      SIZE_W:  ok = (offset[1:0] == 2'b00);
      default: ok = (offset == 3'b000);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane handling for one 64-bit memory word.
//   word     in   word read from memory
//   offset   in   byte offset of the access inside the word
//   size     in   access size (SIZE_B/H/W/D)
//   sgn      in   sign-extend (1) or zero-extend (0) the loaded value
//   wdata    in   store data, right-aligned
//   load_val out  selected lanes shifted down and extended to 64 bits
//   merged   out  word with the addressed lanes replaced by wdata
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [2:0]        offset,
  input  logic [1:0]        size,
  input  logic              sgn,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] merged
);

  logic        [5:0]        sh;
  logic        [DATA_W-1:0] shifted;
  logic        [DATA_W-1:0] mask;
  logic signed [7:0]        b_s;
  logic signed [15:0]       h_s;
  logic signed [31:0]       w_s;

  always_comb begin
    sh       = {offset, 3'b000};
    shifted  = word >> sh;
    b_s      = shifted[7:0];
    h_s      = shifted[15:0];
    w_s      = shifted[31:0];
    mask     = '0;
    load_val = '0;
    case (size)
      SIZE_B: begin
        mask = 64'h0000_0000_0000_00FF;
        if (sgn) load_val = DATA_W'(b_s);
        else     load_val = DATA_W'(shifted[7:0]);
      end
      SIZE_H: begin
        mask = 64'h0000_0000_0000_FFFF;
        if (sgn) load_val = DATA_W'(h_s);
        else     load_val = DATA_W'(shifted[15:0]);
      end
      SIZE_W: begin
        mask = 64'h0000_0000_FFFF_FFFF;
        if (sgn) load_val = DATA_W'(w_s);
        else     load_val = DATA_W'(shifted[31:0]);
      end
      default: begin
        mask     = '1;
        load_val = shifted;
      end
    endcase
    // Bytes outside the addressed lanes keep the value that was read.
    merged = (word & ~(mask << sh)) | ((wdata << sh) & (mask << sh));
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the data-memory port for the MEM stage.
// Accepts one load/store at a time, drives the word-indexed memory and returns one
// response. Sub-word loads are lane-extracted and extended; sub-word stores are
// performed as read-modify-write. busy stalls the pipeline while a request is open.
//   clock, reset_n                    clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready               request handshake (ready only in IDLE)
//   req_write/size/signed/addr/wdata  request fields
//   resp_valid/resp_rdata/resp_err    one-cycle response pulse, load data, misalignment flag
//   busy                              any state other than IDLE
//   mem_address/mem_write_data        word index and full write word (registered)
//   mem_MemWrite/mem_MemRead          one-cycle strobes
//   mem_read_data                     memory read data, valid RD_LATENCY cycles after MemRead
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int RD_LATENCY = 0,
  parameter int AW         = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int CNT_W  = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
  localparam int LAST_I = (RD_LATENCY > 0) ? RD_LATENCY - 1 : 0;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         off_p1;
  logic [1:0]         size_p1;
  logic               sgn_p1;
  logic               wr_p1;
  logic [DATA_W-1:0]  wdata_p1;
  logic [DATA_W-1:0]  load_val;
  logic [DATA_W-1:0]  merged;
  logic               capture;

  mem_lane_align u_align (
    .word     (mem_read_data),
    .offset   (off_p1),
    .size     (size_p1),
    .sgn      (sgn_p1),
    .wdata    (wdata_p1),
    .load_val (load_val),
    .merged   (merged)
  );

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Read data is taken in the last cycle of the read window: RD itself when the
  // memory answers in the same cycle, otherwise the final RD_WAIT cycle.
  assign capture = ((state == RD) && (RD_LATENCY == 0)) ||
                   ((state == RD_WAIT) && (cnt == CNT_W'(LAST_I)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      off_p1         <= '0;
      size_p1        <= '0;
      sgn_p1         <= 1'b0;
      wr_p1          <= 1'b0;
      wdata_p1       <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_MemWrite   <= 1'b0;
      mem_MemRead    <= 1'b0;
    end else begin
      case (state)
        // Stage p0: accept and classify the request
        IDLE: begin
          if (req_valid) begin
            off_p1     <= req_addr[2:0];
            size_p1    <= req_size;
            sgn_p1     <= req_signed;
            wr_p1      <= req_write;
            wdata_p1   <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            if (!is_aligned(req_addr[2:0], req_size)) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              state      <= ERR;
            end else begin
              mem_address <= DATA_W'(req_addr[AW-1:3]);
              if (req_write && (req_size == SIZE_D)) begin
                mem_write_data <= req_wdata;
                mem_MemWrite   <= 1'b1;
                state          <= WR;
              end else begin
                mem_MemRead <= 1'b1;
                state       <= RD;
              end
            end
          end
        end
        // Stage p1: memory read and latency wait
        RD, RD_WAIT: begin
          mem_MemRead <= 1'b0;
          if (capture) begin
            if (wr_p1) begin
              mem_write_data <= merged;
              mem_MemWrite   <= 1'b1;
              state          <= MERGE_WR;
            end else begin
              resp_valid <= 1'b1;
              resp_rdata <= load_val;
              state      <= RESP;
            end
          end else if (state == RD) begin
            cnt   <= '0;
            state <= RD_WAIT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        // Stage p2: write strobe done, respond
        MERGE_WR, WR: begin
          mem_MemWrite <= 1'b0;
          resp_valid   <= 1'b1;
          state        <= RESP;
        end
        default: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] pre;
    logic [63:0] exp_rdata;
    logic [63:0] exp_wdata;
    logic        err;
  } vec_t;

  localparam int NV = 14;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;

  logic        req_valid      [2];
  logic        req_ready      [2];
  logic        req_write      [2];
  logic [1:0]  req_size       [2];
  logic        req_signed     [2];
  logic [63:0] req_addr       [2];
  logic [63:0] req_wdata      [2];
  logic        resp_valid     [2];
  logic [63:0] resp_rdata     [2];
  logic        resp_err       [2];
  logic        busy           [2];
  logic [63:0] mem_address    [2];
  logic [63:0] mem_write_data [2];
  logic        mem_MemWrite   [2];
  logic        mem_MemRead    [2];
  logic [63:0] mem_read_data  [2];

  logic [63:0] mem [2][16];
  logic [1:0]  rpipe = 2'b00;

  int n_checks = 0;
  int n_pass   = 0;

  int          resp_cyc, rd_cnt, rd_cyc, wr_cnt, wr_cyc;
  logic [63:0] got_rdata, got_wdata, got_addr;
  logic        got_err;

  vec_t vecs [NV];

  always #5 clock = ~clock;

  mem_access_unit #(.RD_LATENCY(0), .AW(64)) dut0 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .busy(busy[0]), .mem_address(mem_address[0]),
    .mem_write_data(mem_write_data[0]), .mem_MemWrite(mem_MemWrite[0]),
    .mem_MemRead(mem_MemRead[0]), .mem_read_data(mem_read_data[0])
  );

  mem_access_unit #(.RD_LATENCY(2), .AW(64)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .busy(busy[1]), .mem_address(mem_address[1]),
    .mem_write_data(mem_write_data[1]), .mem_MemWrite(mem_MemWrite[1]),
    .mem_MemRead(mem_MemRead[1]), .mem_read_data(mem_read_data[1])
  );

  // Memory models: instance 0 answers in the MemRead cycle, instance 1 only
  // RD_LATENCY=2 cycles later (garbage otherwise).
  assign mem_read_data[0] = mem[0][mem_address[0][3:0]];
  assign mem_read_data[1] = rpipe[1] ? mem[1][mem_address[1][3:0]] : 64'hDEAD_BEEF_DEAD_BEEF;

  always @(posedge clock) begin
    if (mem_MemWrite[0]) mem[0][mem_address[0][3:0]] = mem_write_data[0];
    if (mem_MemWrite[1]) mem[1][mem_address[1][3:0]] = mem_write_data[1];
    rpipe <= {rpipe[0], mem_MemRead[1]};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
  endtask

  task automatic drive(input int k, input vec_t v);
    req_write[k]  = v.wr;
    req_size[k]   = v.size;
    req_signed[k] = v.sgn;
    req_addr[k]   = v.addr;
    req_wdata[k]  = v.wdata;
    req_valid[k]  = 1'b1;
  endtask

  // Called at #1 after the accepting edge; samples each cycle until resp_valid
  // (bounded), recording strobe activity. resp_cyc stays 0 on timeout.
  task automatic collect(input int k);
    resp_cyc = 0; rd_cnt = 0; rd_cyc = 0; wr_cnt = 0; wr_cyc = 0;
    got_rdata = '0; got_wdata = '0; got_addr = '0; got_err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (mem_MemRead[k]) begin
        rd_cnt++; rd_cyc = n; got_addr = mem_address[k];
      end
      if (mem_MemWrite[k]) begin
        wr_cnt++; wr_cyc = n; got_wdata = mem_write_data[k]; got_addr = mem_address[k];
      end
      if (resp_valid[k]) begin
        resp_cyc = n; got_rdata = resp_rdata[k]; got_err = resp_err[k];
        break;
      end
      @(posedge clock); #1;
    end
  endtask

  initial begin
    vec_t v;
    int   lat, exp_resp, exp_rd, exp_wr, saw, found, wcyc;

    //          wr    size   sgn   addr    wdata                   pre                     exp_rdata               exp_wdata               err
    vecs[0]  = '{1'b0, 2'b11, 1'b0, 64'h28, 64'h0,                  64'h1122334455667788,   64'h1122334455667788,   64'h0,                  1'b0};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 64'h2F, 64'h0,                  64'h8000000000000000,   64'hFFFFFFFFFFFFFF80,   64'h0,                  1'b0};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 64'h2F, 64'h0,                  64'h8000000000000000,   64'h0000000000000080,   64'h0,                  1'b0};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 64'h2C, 64'h0,                  64'h1122F34455667788,   64'hFFFFFFFFFFFFF344,   64'h0,                  1'b0};
    vecs[4]  = '{1'b0, 2'b10, 1'b0, 64'h2C, 64'h0,                  64'h89ABCDEF01234567,   64'h0000000089ABCDEF,   64'h0,                  1'b0};
    vecs[5]  = '{1'b0, 2'b10, 1'b1, 64'h28, 64'h0,                  64'h0123456789ABCDEF,   64'hFFFFFFFF89ABCDEF,   64'h0,                  1'b0};
    vecs[6]  = '{1'b1, 2'b01, 1'b0, 64'h0A, 64'hBEEF,               64'h0,                  64'h0,                  64'h00000000BEEF0000,   1'b0};
    vecs[7]  = '{1'b1, 2'b00, 1'b0, 64'h13, 64'hFFFFFFFFFFFFFFAB,   64'h1111111111111111,   64'h0,                  64'h11111111AB111111,   1'b0};
    vecs[8]  = '{1'b1, 2'b11, 1'b0, 64'h18, 64'h0123456789ABCDEF,   64'h0,                  64'h0,                  64'h0123456789ABCDEF,   1'b0};
    vecs[9]  = '{1'b1, 2'b10, 1'b0, 64'h24, 64'hCAFEBABE,           64'hFFFFFFFFFFFFFFFF,   64'h0,                  64'hCAFEBABEFFFFFFFF,   1'b0};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 64'h06, 64'h0,                  64'h0,                  64'h0,                  64'h0,                  1'b1};
    vecs[11] = '{1'b1, 2'b01, 1'b0, 64'h0B, 64'h1234,               64'h0,                  64'h0,                  64'h0,                  1'b1};
    vecs[12] = '{1'b0, 2'b11, 1'b0, 64'h2C, 64'h0,                  64'h0,                  64'h0,                  64'h0,                  1'b1};
    vecs[13] = '{1'b0, 2'b01, 1'b0, 64'h2E, 64'h0,                  64'hF00D000000000000,   64'h000000000000F00D,   64'h0,                  1'b0};

    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_size[k] = 2'b00;
      req_signed[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
      for (int i = 0; i < 16; i++) mem[k][i] = '0;
    end

    // Reset state
    #1 reset_n = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("k%0d_rst_ready", k), req_ready[k], 1);
      chk($sformatf("k%0d_rst_resp_valid", k), resp_valid[k], 0);
      chk($sformatf("k%0d_rst_resp_err", k), resp_err[k], 0);
      chk($sformatf("k%0d_rst_busy", k), busy[k], 0);
      chk($sformatf("k%0d_rst_memread", k), mem_MemRead[k], 0);
      chk($sformatf("k%0d_rst_memwrite", k), mem_MemWrite[k], 0);
      chk($sformatf("k%0d_rst_addr", k), mem_address[k], 0);
      chk($sformatf("k%0d_rst_wdata", k), mem_write_data[k], 0);
      chk($sformatf("k%0d_rst_rdata", k), resp_rdata[k], 0);
    end
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Table-driven single transactions on both latencies
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? 0 : 2;
      for (int i = 0; i < NV; i++) begin
        v = vecs[i];
        mem[k][v.addr[6:3]] = v.pre;
        chk($sformatf("k%0d_v%0d_ready", k, i), req_ready[k], 1);
        drive(k, v);
        @(posedge clock); #1;
        req_valid[k] = 1'b0;
        collect(k);
        exp_resp = v.err ? 1 : (v.wr && v.size == 2'b11) ? 2 : v.wr ? 3 + lat : 2 + lat;
        exp_rd   = (v.err || (v.wr && v.size == 2'b11)) ? 0 : 1;
        exp_wr   = (v.wr && !v.err) ? 1 : 0;
        chk($sformatf("k%0d_v%0d_resp_cycle", k, i), resp_cyc, exp_resp);
        chk($sformatf("k%0d_v%0d_rdata", k, i), got_rdata, v.exp_rdata);
        chk($sformatf("k%0d_v%0d_err", k, i), got_err, v.err);
        chk($sformatf("k%0d_v%0d_read_count", k, i), rd_cnt, exp_rd);
        chk($sformatf("k%0d_v%0d_write_count", k, i), wr_cnt, exp_wr);
        if (exp_rd == 1) chk($sformatf("k%0d_v%0d_read_cycle", k, i), rd_cyc, 1);
        if (exp_wr == 1) begin
          chk($sformatf("k%0d_v%0d_write_cycle", k, i), wr_cyc, (v.size == 2'b11) ? 1 : 2 + lat);
          chk($sformatf("k%0d_v%0d_write_data", k, i), got_wdata, v.exp_wdata);
        end
        if (!v.err) chk($sformatf("k%0d_v%0d_address", k, i), got_addr, v.addr >> 3);
        chk($sformatf("k%0d_v%0d_busy_resp", k, i), busy[k], 1);
        @(posedge clock); #1;
        chk($sformatf("k%0d_v%0d_idle_after", k, i), req_ready[k], 1);
        chk($sformatf("k%0d_v%0d_resp_pulse", k, i), resp_valid[k], 0);
      end
    end

    // Back-to-back: sub-word store then load of the same word, req_valid held
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? 0 : 2;
      mem[k][6] = '0;
      v = '{1'b1, 2'b10, 1'b0, 64'h34, 64'h11223344, 64'h0, 64'h0, 64'h0, 1'b0};
      drive(k, v);
      @(posedge clock); #1;
      v.wr = 1'b0;
      drive(k, v);
      collect(k);
      chk($sformatf("k%0d_b2b_store_resp_cycle", k), resp_cyc, 3 + lat);
      chk($sformatf("k%0d_b2b_store_reads", k), rd_cnt, 1);
      chk($sformatf("k%0d_b2b_store_writes", k), wr_cnt, 1);
      chk($sformatf("k%0d_b2b_store_wdata", k), got_wdata, 64'h11223344_00000000);
      chk($sformatf("k%0d_b2b_ready_in_resp", k), req_ready[k], 0);
      @(posedge clock); #1;
      chk($sformatf("k%0d_b2b_ready_after_resp", k), req_ready[k], 1);
      @(posedge clock); #1;
      req_valid[k] = 1'b0;
      collect(k);
      chk($sformatf("k%0d_b2b_load_resp_cycle", k), resp_cyc, 2 + lat);
      chk($sformatf("k%0d_b2b_load_rdata", k), got_rdata, 64'h11223344);
      chk($sformatf("k%0d_b2b_load_reads", k), rd_cnt, 1);
      chk($sformatf("k%0d_b2b_load_addr", k), got_addr, 64'h6);
      @(posedge clock); #1;
    end

    // Reset in the middle of RD_WAIT (RD_LATENCY=2)
    mem[1][5] = 64'h1122334455667788;
    v = vecs[0];
    drive(1, v);
    @(posedge clock); #1;
    req_valid[1] = 1'b0;
    chk("rstwait_memread_cycle1", mem_MemRead[1], 1);
    @(posedge clock); #1;
    chk("rstwait_busy_before", busy[1], 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstwait_memread", mem_MemRead[1], 0);
    chk("rstwait_memwrite", mem_MemWrite[1], 0);
    chk("rstwait_busy", busy[1], 0);
    chk("rstwait_ready", req_ready[1], 1);
    chk("rstwait_resp_valid", resp_valid[1], 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    saw = 0;
    for (int n = 0; n < 6; n++) begin
      if (resp_valid[1]) saw++;
      @(posedge clock); #1;
    end
    chk("rstwait_no_resp", saw, 0);
    chk("rstwait_ready_after", req_ready[1], 1);

    // Reset while the merged write strobe is up: strobe drops at once, memory untouched
    mem[1][1] = 64'h5555_5555_5555_5555;
    v = vecs[6];
    drive(1, v);
    @(posedge clock); #1;
    req_valid[1] = 1'b0;
    found = 0; wcyc = 0;
    for (int n = 1; n <= 10; n++) begin
      if (mem_MemWrite[1]) begin
        found = 1; wcyc = n;
        break;
      end
      @(posedge clock); #1;
    end
    chk("rstwr_strobe_seen", found, 1);
    chk("rstwr_strobe_cycle", wcyc, 4);
    chk("rstwr_merged_data", mem_write_data[1], 64'h55555555BEEF5555);
    #2 reset_n = 1'b0;
    #1;
    chk("rstwr_memwrite", mem_MemWrite[1], 0);
    chk("rstwr_busy", busy[1], 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("rstwr_mem_kept", mem[1][1], 64'h5555_5555_5555_5555);
    chk("rstwr_no_resp", resp_valid[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
